// File: rtl/pipelined_muldiv_alu.sv
// MIPS-style ALU with the 5-bit opcode set, extended with iterative
// signed/unsigned multiply (full 2*DATA_W product) and divide (quotient + remainder).
// Simple ops take 1 cycle, MUL/DIV take DATA_W+2 cycles, divide-by-zero takes 1 cycle.
// valid/ready handshake: one op in flight; results are held in DONE until out_ready.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready, Src_A, Src_B, shamt,
//        ALU_control, flush, out_valid/out_ready, result, result_hi, zero, N, V, C, dz.
module pipelined_muldiv_alu #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  Src_A,
  input  logic [DATA_W-1:0]  Src_B,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [4:0]         ALU_control,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic [DATA_W-1:0]  result_hi,
  output logic               zero,
  output logic               N,
  output logic               V,
  output logic               C,
  output logic               dz
);

  localparam logic [4:0] OP_AND  = 5'b00000, OP_OR   = 5'b00001, OP_ADD  = 5'b00010,
                         OP_XOR  = 5'b00011, OP_SRB  = 5'b00100, OP_ADDU = 5'b00101,
                         OP_SUB  = 5'b00110, OP_SLT  = 5'b00111, OP_SLL  = 5'b01000,
                         OP_SRL  = 5'b01001, OP_SRA  = 5'b01010, OP_SUBU = 5'b01011,
                         OP_NOR  = 5'b01100, OP_SLTU = 5'b01101, OP_MUL  = 5'b01110,
                         OP_DIV  = 5'b01111, OP_MULU = 5'b10000, OP_DIVU = 5'b10001,
                         OP_SLLV = 5'b10100, OP_SRLV = 5'b10101, OP_SRAV = 5'b10110;

  localparam logic [SHAMT_W-1:0] LAST_BIT = SHAMT_W'(DATA_W - 1);
  localparam int MSB = DATA_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state, state_nxt;

  // Latched operation context for the iterative path
  logic               op_mul;      // 1: multiply, 0: divide
  logic               op_signed;
  logic               neg_lo;      // negate product / quotient in FIX
  logic               neg_hi;      // negate remainder in FIX (dividend sign)
  logic               div_ovf;     // signed MIN / -1
  logic [DATA_W-1:0]  mag_b;
  logic [DATA_W-1:0]  p_hi;        // product high / partial remainder
  logic [DATA_W-1:0]  p_lo;        // multiplier bits / quotient bits
  logic [SHAMT_W-1:0] count;

  // ---------------- request decode ----------------
  logic              accept, is_md, is_div, div_zero, go_calc, signed_in, a_neg, b_neg;
  logic [DATA_W-1:0] mag_a_in, mag_b_in;

  assign accept    = (state == S_IDLE) && in_valid && !flush;
  is_md_decode: assert property (@(posedge clk) 1'b1);
  assign is_div    = (ALU_control == OP_DIV) || (ALU_control == OP_DIVU);
  assign is_md     = is_div || (ALU_control == OP_MUL) || (ALU_control == OP_MULU);
  assign div_zero  = is_div && (Src_B == '0);
  assign go_calc   = is_md && !div_zero;
  assign signed_in = (ALU_control == OP_MUL) || (ALU_control == OP_DIV);
  assign a_neg     = signed_in && Src_A[MSB];
  assign b_neg     = signed_in && Src_B[MSB];
  assign mag_a_in  = a_neg ? -Src_A : Src_A;
  assign mag_b_in  = b_neg ? -Src_B : Src_B;

  // ---------------- single-cycle ALU ----------------
  logic [DATA_W:0]    sum_w, diff_w;
  logic [SHAMT_W-1:0] var_sh;
  logic [DATA_W-1:0]  s_res, s_hi;
  logic               s_known, s_v, s_c, s_dz, s_zero;

  assign sum_w  = {1'b0, Src_A} + {1'b0, Src_B};
  assign diff_w = {1'b0, Src_A} - {1'b0, Src_B};
  assign var_sh = Src_A[SHAMT_W-1:0];

  always_comb begin
    s_res   = '0;
    s_hi    = '0;
    s_known = 1'b1;
    s_v     = 1'b0;
    s_c     = 1'b0;
    s_dz    = 1'b0;
    case (ALU_control)
      OP_AND:  s_res = Src_A & Src_B;
      OP_OR:   s_res = Src_A | Src_B;
      OP_XOR:  s_res = Src_A ^ Src_B;
      OP_NOR:  s_res = ~(Src_A | Src_B);
      OP_ADD: begin
        s_res = sum_w[MSB:0];
        s_c   = sum_w[DATA_W];
        s_v   = (Src_A[MSB] == Src_B[MSB]) && (sum_w[MSB] != Src_A[MSB]);
      end
      OP_ADDU: begin
        s_res = sum_w[MSB:0];
        s_c   = sum_w[DATA_W];
      end
      OP_SUB: begin
        s_res = diff_w[MSB:0];
        s_c   = diff_w[DATA_W];   // borrow == (A < B) unsigned
        s_v   = (Src_A[MSB] != Src_B[MSB]) && (diff_w[MSB] != Src_A[MSB]);
      end
      OP_SUBU: begin
        s_res = diff_w[MSB:0];
        s_c   = diff_w[DATA_W];
      end
      OP_SLT:  s_res = ($signed(Src_A) < $signed(Src_B)) ? DATA_W'(1) : '0;
      OP_SLTU: s_res = (Src_A < Src_B) ? DATA_W'(1) : '0;
      OP_SLL:  s_res = Src_B << shamt;
      OP_SRL:  s_res = Src_B >> shamt;
      OP_SRA:  s_res = $signed(Src_B) >>> shamt;
      OP_SLLV: s_res = Src_B << var_sh;
      OP_SRLV: s_res = Src_B >> var_sh;
      OP_SRAV: s_res = $signed(Src_B) >>> var_sh;
      OP_SRB:  s_res = Src_B;     // pass operand B through
      OP_DIV, OP_DIVU: begin      // only reaches the output on divide-by-zero
        s_res = '1;
        s_hi  = Src_A;
        s_dz  = 1'b1;
      end
      OP_MUL, OP_MULU: s_known = 1'b1;
      default: s_known = 1'b0;    // unknown opcode: everything 0, including zero
    endcase
    s_zero = s_known && (s_res == '0);
  end

  // ---------------- iterative step / sign fix ----------------
  logic [DATA_W:0]     mul_sum, div_sh, div_sub;
  logic                div_ge;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  assign mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mag_b} : '0);
  assign div_sh   = {p_hi, p_lo[MSB]};
  assign div_ge   = div_sh >= {1'b0, mag_b};
  assign div_sub  = div_sh - {1'b0, mag_b};
  assign prod_fix = neg_lo ? -{p_hi, p_lo} : {p_hi, p_lo};
  assign quo_fix  = neg_lo ? -p_lo : p_lo;
  assign rem_fix  = neg_hi ? -p_hi : p_hi;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = go_calc ? S_CALC : S_DONE;
      S_CALC: if (flush) state_nxt = S_IDLE;
              else if (count == LAST_BIT) state_nxt = S_FIX;
      S_FIX:  state_nxt = flush ? S_IDLE : S_DONE;
      S_DONE: if (flush || out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n || (flush && state != S_IDLE)) begin
      result <= '0; result_hi <= '0;
      zero <= 1'b0; N <= 1'b0; V <= 1'b0; C <= 1'b0; dz <= 1'b0;
      op_mul <= 1'b0; op_signed <= 1'b0; neg_lo <= 1'b0; neg_hi <= 1'b0; div_ovf <= 1'b0;
      mag_b <= '0; p_hi <= '0; p_lo <= '0; count <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          if (go_calc) begin
            op_mul    <= !is_div;
            op_signed <= signed_in;
            neg_lo    <= a_neg ^ b_neg;
            neg_hi    <= a_neg;
            div_ovf   <= signed_in && is_div && (Src_A == {1'b1, {(DATA_W-1){1'b0}}}) &&
                         (Src_B == '1);
            mag_b     <= mag_b_in;
            p_hi      <= '0;
            p_lo      <= mag_a_in;
            count     <= '0;
          end else begin
            result    <= s_res;
            result_hi <= s_hi;
            zero      <= s_zero;
            N         <= s_res[MSB];
            V         <= s_v;
            C         <= s_c;
            dz        <= s_dz;
          end
        end
        S_CALC: begin
          count <= count + 1'b1;
          if (op_mul) begin
            // shift-add: LSB of p_lo selects whether B is added to the high half
            {p_hi, p_lo} <= {mul_sum, p_lo[MSB:1]};
          end else begin
            // restoring division: shift next dividend bit into the remainder
            p_hi <= div_ge ? div_sub[MSB:0] : div_sh[MSB:0];
            p_lo <= {p_lo[MSB-1:0], div_ge};
          end
        end
        S_FIX: begin
          C  <= 1'b0;
          dz <= 1'b0;
          if (op_mul) begin
            result    <= prod_fix[MSB:0];
            result_hi <= prod_fix[2*DATA_W-1:DATA_W];
            zero      <= (prod_fix == '0);
            N         <= prod_fix[MSB];
            V         <= op_signed ? (prod_fix[2*DATA_W-1:DATA_W] != {DATA_W{prod_fix[MSB]}})
                                   : (prod_fix[2*DATA_W-1:DATA_W] != '0);
          end else begin
            result    <= quo_fix;
            result_hi <= rem_fix;
            zero      <= (quo_fix == '0);
            N         <= quo_fix[MSB];
            V         <= div_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
